// File: rtl/alarm_ring_ctrl_pkg.sv
// ============================================================================
// alarm_ring_ctrl_pkg : shared types and constants for the alarm ring sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_ring_ctrl_pkg;

    localparam int TIME_W    = 20;
    localparam int SNZ_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_RINGING = 2'b10,
        ST_SNOOZE  = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_ring_ctrl_tick_sec_counter.sv
// ============================================================================
// alarm_ring_ctrl_tick_sec_counter : counts 1 Hz ticks up to LIMIT-1, flags the last one
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ring_ctrl_tick_sec_counter #(
    parameter int LIMIT = 60,
    parameter int CNT_W = 9
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_sys) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (tick) begin
            // Return to zero on the final tick so the count never passes LIMIT-1.
            if (r_count == C_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign done = tick && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
// ============================================================================
// alarm_ring_ctrl : alarm match detection, ring/snooze/timeout sequencing
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [TIME_W-1:0]     now_time,
    input  logic [TIME_W-1:0]     alarm_time,
    input  logic                  alarm_en,
    input  logic                  cfg_busy,
    input  logic                  btn_snooze,
    input  logic                  btn_stop,
    output logic                  ring,
    output logic                  snoozing,
    output logic [SNZ_CNT_W-1:0]  snooze_cnt,
    output logic                  missed,
    output logic [1:0]            state_o
);

    localparam logic [SNZ_CNT_W-1:0] C_MAX_SNOOZE = SNZ_CNT_W'(MAX_SNOOZE);

    state_t               r_state;
    state_t               w_next_state;
    logic [SNZ_CNT_W-1:0] r_snooze_cnt;
    logic [SNZ_CNT_W-1:0] w_next_snooze_cnt;
    logic                 r_missed;
    logic                 w_next_missed;
    logic                 r_eq_prev;

    logic w_time_eq;
    logic w_match_evt;
    logic w_can_snooze;
    logic w_ring_tick;
    logic w_snz_tick;
    logic w_ring_done;
    logic w_snz_done;

    // History tracks raw equality, so an alarm edited onto the current time
    // while cfg_busy is up is already "old" when editing ends and cannot fire.
    assign w_time_eq    = (now_time == alarm_time);
    assign w_match_evt  = w_time_eq && !cfg_busy && !r_eq_prev;
    assign w_can_snooze = (r_snooze_cnt < C_MAX_SNOOZE);

    // A tick only advances a timer when no higher-priority action consumes the cycle.
    assign w_ring_tick = alarm_en && (r_state == ST_RINGING) && tick_1hz && !btn_stop
                         && !(btn_snooze && w_can_snooze);
    assign w_snz_tick  = alarm_en && (r_state == ST_SNOOZE) && tick_1hz && !btn_stop;

    alarm_ring_ctrl_tick_sec_counter #(
        .LIMIT (RING_SECS),
        .CNT_W (CNT_W)
    ) u_ring_timer (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clear   (r_state != ST_RINGING),
        .tick    (w_ring_tick),
        .done    (w_ring_done)
    );

    alarm_ring_ctrl_tick_sec_counter #(
        .LIMIT (SNOOZE_SECS),
        .CNT_W (CNT_W)
    ) u_snooze_timer (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clear   (r_state != ST_SNOOZE),
        .tick    (w_snz_tick),
        .done    (w_snz_done)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_snooze_cnt <= '0;
            r_missed     <= 1'b0;
            r_eq_prev    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_snooze_cnt <= w_next_snooze_cnt;
            r_missed     <= w_next_missed;
            r_eq_prev    <= w_time_eq;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_snooze_cnt = r_snooze_cnt;
        w_next_missed     = 1'b0;
        if (!alarm_en) begin
            w_next_state      = ST_IDLE;
            w_next_snooze_cnt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_match_evt) begin
                        w_next_state      = ST_RINGING;
                        w_next_snooze_cnt = '0;
                    end
                end
                ST_RINGING: begin
                    if (btn_stop) begin
                        w_next_state      = ST_ARMED;
                        w_next_snooze_cnt = '0;
                    end else if (btn_snooze && w_can_snooze) begin
                        w_next_state      = ST_SNOOZE;
                        w_next_snooze_cnt = r_snooze_cnt + SNZ_CNT_W'(1);
                    end else if (w_ring_done) begin
                        w_next_state      = ST_ARMED;
                        w_next_snooze_cnt = '0;
                        w_next_missed     = 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (btn_stop) begin
                        w_next_state      = ST_ARMED;
                        w_next_snooze_cnt = '0;
                    end else if (w_snz_done) begin
                        w_next_state = ST_RINGING;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    assign ring       = (r_state == ST_RINGING);
    assign snoozing   = (r_state == ST_SNOOZE);
    assign snooze_cnt = r_snooze_cnt;
    assign missed     = r_missed;
    assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
// ============================================================================
// tb_alarm_ring_ctrl : directed + randomized check of alarm_ring_ctrl against a behavioural model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ring_ctrl;

    localparam int RING_SECS   = 5;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZE  = 2;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic [19:0] now_time = '0;
    logic [19:0] alarm_time = '0;
    logic        alarm_en = 1'b0;
    logic        cfg_busy = 1'b0;
    logic        btn_snooze = 1'b0;
    logic        btn_stop = 1'b0;
    logic        ring;
    logic        snoozing;
    logic [1:0]  snooze_cnt;
    logic        missed;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: state names as the display codes, timers as seconds remaining.
    int  m_mode = 0;
    int  m_snoozes = 0;
    int  m_ring_left = 0;
    int  m_snz_left = 0;
    bit  m_missed = 0;
    bit  m_seen_equal = 0;

    alarm_ring_ctrl #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE),
        .CNT_W       (9)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .now_time   (now_time),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .cfg_busy   (cfg_busy),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .ring       (ring),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .missed     (missed),
        .state_o    (state_o)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [19:0] to_bcd(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit fresh;
        if (rst) begin
            m_mode = 0; m_snoozes = 0; m_missed = 0; m_seen_equal = 0;
            return;
        end
        fresh = (now_time == alarm_time) && !cfg_busy && !m_seen_equal;
        m_seen_equal = (now_time == alarm_time);
        m_missed = 0;
        if (!alarm_en) begin
            m_mode = 0; m_snoozes = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (fresh) begin
                m_mode = 2; m_snoozes = 0; m_ring_left = RING_SECS;
            end
        end else if (m_mode == 2) begin
            if (btn_stop) begin
                m_mode = 1; m_snoozes = 0;
            end else if (btn_snooze && m_snoozes < MAX_SNOOZE) begin
                m_mode = 3; m_snoozes++; m_snz_left = SNOOZE_SECS;
            end else if (tick_1hz) begin
                m_ring_left--;
                if (m_ring_left == 0) begin
                    m_mode = 1; m_snoozes = 0; m_missed = 1;
                end
            end
        end else begin
            if (btn_stop) begin
                m_mode = 1; m_snoozes = 0;
            end else if (tick_1hz) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = 2; m_ring_left = RING_SECS;
                end
            end
        end
    endtask

    // One clock: apply pulses, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input logic t, input logic snz, input logic stp);
        tick_1hz = t; btn_snooze = snz; btn_stop = stp;
        @(posedge clk_sys);
        model_step();
        #1;
        chk("state", int'(state_o), m_mode);
        chk("ring", int'(ring), int'(m_mode == 2));
        chk("snoozing", int'(snoozing), int'(m_mode == 3));
        chk("snooze_cnt", int'(snooze_cnt), m_snoozes);
        chk("missed", int'(missed), int'(m_missed));
        tick_1hz = 0; btn_snooze = 0; btn_stop = 0;
    endtask

    task automatic ring_up();
        now_time = to_bcd(7, 29, 59); cyc(0, 0, 0);
        now_time = to_bcd(7, 30, 0);  cyc(0, 0, 0);
    endtask

    initial begin
        int ah, am, as_;
        rst = 1; alarm_en = 0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_ring", int'(ring), 0);
        rst = 0;

        alarm_time = to_bcd(7, 30, 0);
        now_time = to_bcd(7, 29, 59);
        alarm_en = 1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("armed", int'(state_o), 1);
        now_time = to_bcd(7, 30, 0); cyc(0, 0, 0);
        chk("match_ring", int'(ring), 1);
        chk("match_state", int'(state_o), 2);

        for (int i = 0; i < RING_SECS - 1; i++) begin
            cyc(1, 0, 0); cyc(0, 0, 0);
        end
        chk("no_early_timeout", int'(ring), 1);
        cyc(1, 0, 0);
        chk("timeout_missed", int'(missed), 1);
        chk("timeout_ring", int'(ring), 0);
        chk("timeout_state", int'(state_o), 1);
        cyc(0, 0, 0);
        chk("missed_pulse", int'(missed), 0);

        ring_up();
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            cyc(0, 1, 0);
            chk("snz_on", int'(snoozing), 1);
            chk("snz_cnt", int'(snooze_cnt), k);
            for (int i = 0; i < SNOOZE_SECS; i++) cyc(1, 0, 0);
            chk("rering", int'(ring), 1);
        end
        cyc(0, 1, 0);
        chk("snz_limit_state", int'(state_o), 2);
        chk("snz_limit_cnt", int'(snooze_cnt), MAX_SNOOZE);
        cyc(0, 1, 1);
        chk("stop_wins_state", int'(state_o), 1);
        chk("stop_wins_cnt", int'(snooze_cnt), 0);
        chk("stop_wins_snz", int'(snoozing), 0);

        now_time = to_bcd(8, 0, 0); cyc(0, 0, 0);
        cfg_busy = 1; alarm_time = to_bcd(8, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cfg_busy = 0; cyc(0, 0, 0); cyc(0, 0, 0);
        chk("busy_no_ring", int'(ring), 0);
        now_time = to_bcd(8, 0, 1); cyc(0, 0, 0);
        now_time = to_bcd(8, 0, 0); cyc(0, 0, 0);
        chk("genuine_edge_ring", int'(ring), 1);

        alarm_en = 0; cyc(0, 0, 0);
        chk("dis_state", int'(state_o), 0);
        chk("dis_ring", int'(ring), 0);
        alarm_en = 1; cyc(0, 0, 0); cyc(0, 0, 0);
        chk("reen_no_ring", int'(ring), 0);

        alarm_time = to_bcd(7, 30, 0);
        ring_up();
        chk("ring_before_rst", int'(ring), 1);
        rst = 1; cyc(0, 0, 0);
        chk("rst_mid_ring", int'(ring), 0);
        chk("rst_mid_state", int'(state_o), 0);
        rst = 0; cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("post_rst_no_ring", int'(ring), 0);

        // Randomized phase: times hover around the alarm so equality edges are frequent.
        ah = 7; am = 30; as_ = 0;
        for (int n = 0; n < 4000; n++) begin
            logic t, snz, stp;
            int r;
            rst = ($urandom_range(0, 599) == 0);
            alarm_en = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 299) == 0) begin
                cfg_busy = 1;
                ah = $urandom_range(0, 23); am = $urandom_range(0, 59); as_ = $urandom_range(0, 59);
                alarm_time = to_bcd(ah, am, as_);
            end else if ($urandom_range(0, 5) == 0) begin
                cfg_busy = 0;
            end
            r = $urandom_range(0, 7);
            if (r == 0)      now_time = to_bcd(ah, am, as_);
            else if (r == 1) now_time = to_bcd(ah, am, (as_ + 1) % 60);
            else if (r == 2) now_time = to_bcd($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            t   = ($urandom_range(0, 2) == 0);
            snz = !t && ($urandom_range(0, 7) == 0);
            stp = !t && ($urandom_range(0, 24) == 0);
            cyc(t, snz, stp);
        end
        rst = 0; cfg_busy = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
